regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-read-port register file for the picorv32 core, implemented in distributed RAM.
- One synchronous write port and two asynchronous read ports, rs1 and rs2, so the core no longer needs duplicated single-read instances.
- Distributed RAM has no reset, so a built-in clear sequencer zeroes every entry after reset or on request.
- Optional hard-wired zero register (x0) and optional same-cycle write bypass.

Parameters:
- DATA_WIDTH, 32, bits per entry.
- ADDR_WIDTH, 5, address bits.
- DATA_DEPTH, 32, number of entries; must equal 2**ADDR_WIDTH.
- ZERO_REG, 1, when 1, entry 0 always reads 0 and writes to address 0 are discarded.

Ports:
- wclk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  request a full clear; sampled only in READY.
- we  in  1  write enable.
- waddr  in  ADDR_WIDTH  write address.
- di  in  DATA_WIDTH  write data.
- raddr_a  in  ADDR_WIDTH  read address, port A.
- raddr_b  in  ADDR_WIDTH  read address, port B.
- do_a  out  DATA_WIDTH  read data, port A (combinational).
- do_b  out  DATA_WIDTH  read data, port B (combinational).
- busy  out  1  high while clearing.
- wr_drop  out  1  one-cycle registered pulse: a user write was discarded because busy was high.

Behaviour:
- Storage: DATA_DEPTH x DATA_WIDTH array with one write port.
  - Both read ports see the same contents.
  - Implement as two DRAM copies written in parallel, or one multi-read array.
- Read: do_x = mem[raddr_x], combinational, zero cycles latency.
  - A write becomes visible after the rising edge that commits it.
  - Forced to 0 when busy=1.
  - Forced to 0 when ZERO_REG=1 and raddr_x==0.
- Write: on rising edge, if state==READY and we=1, mem[waddr] <= di.
  - If ZERO_REG=1 and waddr==0, the write is discarded with no wr_drop.
- FSM states: CLEAR, READY. A register clr_cnt[ADDR_WIDTH-1:0] counts clear progress.
  - rst=1: state<=CLEAR, clr_cnt<=0, wr_drop<=0. Entry 0 is written with 0 while rst is held.
  - CLEAR, rst=0: mem[clr_cnt]<=0 and clr_cnt<=clr_cnt+1.
    - When clr_cnt==DATA_DEPTH-1, state<=READY and clr_cnt wraps to 0.
    - clr is ignored in CLEAR.
  - READY, clr=1: state<=CLEAR, clr_cnt<=0. A we in that same cycle is still committed.
  - busy = (state==CLEAR), decoded directly from the state register.
  - Reset output values: busy=1, wr_drop=0, do_a=do_b=0.
- Clear timing: busy falls exactly DATA_DEPTH rising edges after the first edge with rst=0 (or after the edge that accepted clr).
- wr_drop: registered <= (state==CLEAR && we && !rst).
  - The ZERO_REG discard of address 0 during CLEAR still counts as a drop.
- Simultaneous events:
  - rst overrides clr and we.
  - rst mid-clear restarts the clear from entry 0.
  - waddr==raddr_a==raddr_b is legal; both ports show the old value until the edge (unless the bypass below is enabled).

Optional Feature:
- Macro REGFILE_MP_BYPASS_EN.
- Defined: when state==READY, we=1 and waddr==raddr_x (and not a discarded address-0 write), do_x = di in the same cycle, combinationally.
  - busy and ZERO_REG forcing still take priority.
- Undefined: no bypass; do_x shows the stored value until the write edge. This matches the core's existing forwarding assumptions.

Test Plan (defaults, macro undefined unless noted):
- Hold rst 3 cycles, release -> busy=1 for exactly 32 edges, then 0; do_a/do_b=0 throughout; afterwards every address reads 0.
- READY: write 0xDEADBEEF to 5 and 0x12345678 to 31 -> next cycle raddr_a=5, raddr_b=31 give 0xDEADBEEF / 0x12345678; same cycle as the write, raddr_a=5 still shows 0.
- Write 0xFFFFFFFF to address 0 -> do_a with raddr_a=0 reads 0; wr_drop stays 0.
- Pulse clr in READY with we=1 to addr 3 -> the write commits, busy=1 for 32 edges; a we during busy gives wr_drop=1 the following cycle; after clear, addr 3 reads 0.
- Assert rst at clr_cnt=10 -> clear restarts; busy=0 only 32 edges after rst release.
- With REGFILE_MP_BYPASS_EN: we=1, waddr=7, di=0xA5A5A5A5, raddr_b=7 -> do_b=0xA5A5A5A5 in the same cycle.

Source files
------------

// File: rtl/regfile_mp.sv
// Two-read, one-write register file with a built-in clear sequencer for distributed RAM.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_DEPTH = 32,
  parameter int ZERO_REG   = 1
) (
  input  logic                  wclk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] di,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] do_a,
  output logic [DATA_WIDTH-1:0] do_b,
  output logic                  busy,
  output logic                  wr_drop
);

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LastEntry = ADDR_WIDTH'(DATA_DEPTH - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clrCnt_q, clrCnt_d;
  logic                    wrDrop_q, wrDrop_d;
  logic [DATA_WIDTH-1:0]   mem_q [DATA_DEPTH];

  logic                    zeroDiscard;
  logic                    memWe;
  logic [ADDR_WIDTH-1:0]   memWaddr;
  logic [DATA_WIDTH-1:0]   memWdata;
  logic [ADDR_WIDTH-1:0]   rAddr [2];
  logic [DATA_WIDTH-1:0]   rData [2];

  assign zeroDiscard = (ZERO_REG != 0) && (waddr == '0);

  always_comb begin
    state_d  = state_q;
    clrCnt_d = clrCnt_q;
    wrDrop_d = 1'b0;
    if (rst) begin
      state_d  = CLEAR;
      clrCnt_d = '0;
    end else begin
      case (state_q)
        CLEAR: begin
          wrDrop_d = we;
          clrCnt_d = clrCnt_q + 1'b1;
          if (clrCnt_q == LastEntry) begin
            state_d  = READY;
            clrCnt_d = '0;
          end
        end
        READY: begin
          if (clr) begin
            state_d  = CLEAR;
            clrCnt_d = '0;
          end
        end
        default: state_d = CLEAR;
      endcase
    end
  end

  always_ff @(posedge wclk) begin
    if (rst) begin
      state_q  <= CLEAR;
      clrCnt_q <= '0;
      wrDrop_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      clrCnt_q <= clrCnt_d;
      wrDrop_q <= wrDrop_d;
    end
  end

  // Single write port shared by reset, the clear sweep and user writes, in that priority.
  always_comb begin
    memWe    = 1'b0;
    memWaddr = waddr;
    memWdata = di;
    if (rst) begin
      memWe    = 1'b1;
      memWaddr = '0;
      memWdata = '0;
    end else if (state_q == CLEAR) begin
      memWe    = 1'b1;
      memWaddr = clrCnt_q;
      memWdata = '0;
    end else if (we && !zeroDiscard) begin
      memWe    = 1'b1;
    end
  end

  always_ff @(posedge wclk) begin
    if (memWe) begin
      mem_q[memWaddr] <= memWdata;
    end
  end

  assign rAddr[0] = raddr_a;
  assign rAddr[1] = raddr_b;

  // Later assignments win: busy forcing beats x0 forcing beats bypass beats stored data.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rData[p] = mem_q[rAddr[p]];
`ifdef REGFILE_MP_BYPASS_EN
      if (state_q == READY && we && !zeroDiscard && waddr == rAddr[p]) begin
        rData[p] = di;
      end
`endif
      if (ZERO_REG != 0 && rAddr[p] == '0) begin
        rData[p] = '0;
      end
      if (state_q == CLEAR) begin
        rData[p] = '0;
      end
    end
  end

  assign do_a    = rData[0];
  assign do_b    = rData[1];
  assign busy    = (state_q == CLEAR);
  assign wr_drop = wrDrop_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised bench for regfile_mp: an array-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_regfile_mp;

  logic        wclk;
  logic        rst;
  logic        clr;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] di;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic [31:0] do_a;
  logic [31:0] do_b;
  logic        busy;
  logic        wr_drop;

  int vectors;
  int miscompares;

  regfile_mp #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .DATA_DEPTH(32),
    .ZERO_REG  (1)
  ) dut (
    .wclk   (wclk),
    .rst    (rst),
    .clr    (clr),
    .we     (we),
    .waddr  (waddr),
    .di     (di),
    .raddr_a(raddr_a),
    .raddr_b(raddr_b),
    .do_a   (do_a),
    .do_b   (do_b),
    .busy   (busy),
    .wr_drop(wr_drop)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Reference model: contents as a plain array, clearing as a count of remaining busy edges.
  logic [31:0] modelMem [32];
  int          busyLeft;
  bit          modelDrop;
  bit          modelValid;

  initial begin
    modelValid = 1'b0;
    busyLeft   = 0;
    modelDrop  = 1'b0;
    for (int i = 0; i < 32; i++) modelMem[i] = '0;
  end

  always @(posedge wclk) begin
    if (rst) begin
      modelValid = 1'b1;
      busyLeft   = 32;
      modelDrop  = 1'b0;
      for (int i = 0; i < 32; i++) modelMem[i] = '0;
    end else if (modelValid) begin
      if (busyLeft > 0) begin
        modelDrop = we;
        busyLeft  = busyLeft - 1;
      end else begin
        modelDrop = 1'b0;
        if (we && waddr != 5'd0) modelMem[waddr] = di;
        if (clr) begin
          busyLeft = 32;
          for (int i = 0; i < 32; i++) modelMem[i] = '0;
        end
      end
    end
  end

  function automatic logic [31:0] expRead(input logic [4:0] addr);
    if (busyLeft > 0) return 32'd0;
    if (addr == 5'd0) return 32'd0;
`ifdef REGFILE_MP_BYPASS_EN
    if (we && waddr == addr) return di;
`endif
    return modelMem[addr];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  always @(negedge wclk) begin
    if (modelValid) begin
      checkOutput("model_do_a", do_a, expRead(raddr_a));
      checkOutput("model_do_b", do_b, expRead(raddr_b));
      checkOutput("model_busy", {31'd0, busy}, {31'd0, busyLeft > 0});
      checkOutput("model_wr_drop", {31'd0, wr_drop}, {31'd0, modelDrop});
    end
  end

  task automatic applyStimulus(input logic rst_, input logic clr_, input logic we_,
                               input logic [4:0] waddr_, input logic [31:0] di_,
                               input logic [4:0] ra_, input logic [4:0] rb_);
    @(posedge wclk);
    #1;
    rst     = rst_;
    clr     = clr_;
    we      = we_;
    waddr   = waddr_;
    di      = di_;
    raddr_a = ra_;
    raddr_b = rb_;
  endtask

  task automatic countBusyEdges(input int start, output int n);
    n = start;
    while (busy && n < 100) begin
      @(posedge wclk);
      #1;
      raddr_a = 5'($urandom);
      raddr_b = 5'($urandom);
      n++;
    end
  endtask

  int n;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst     = 1'b1;
    clr     = 1'b0;
    we      = 1'b0;
    waddr   = '0;
    di      = '0;
    raddr_a = '0;
    raddr_b = '0;

    repeat (3) applyStimulus(1, 0, 0, 0, 0, 5'd4, 5'd9);
    @(negedge wclk);
    checkOutput("reset_busy", {31'd0, busy}, 32'd1);
    checkOutput("reset_do_a", do_a, 32'd0);
    checkOutput("reset_wr_drop", {31'd0, wr_drop}, 32'd0);

    applyStimulus(0, 0, 0, 0, 0, 5'd1, 5'd2);
    countBusyEdges(0, n);
    checkOutput("reset_clear_edges", n, 32'd32);

    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
      @(negedge wclk);
      checkOutput("post_clear_zero", do_a | do_b, 32'd0);
    end

    applyStimulus(0, 0, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd31);
    @(negedge wclk);
    checkOutput("same_cycle_old", do_a, 32'd0);
    applyStimulus(0, 0, 1, 5'd31, 32'h12345678, 5'd5, 5'd31);
    @(negedge wclk);
    checkOutput("write5_visible", do_a, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 5'd0, 32'd0, 5'd5, 5'd31);
    @(negedge wclk);
    checkOutput("read_a_5", do_a, 32'hDEADBEEF);
    checkOutput("read_b_31", do_b, 32'h12345678);

    applyStimulus(0, 0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5);
    applyStimulus(0, 0, 0, 5'd0, 32'd0, 5'd0, 5'd5);
    @(negedge wclk);
    checkOutput("x0_reads_zero", do_a, 32'd0);
    checkOutput("x0_no_drop", {31'd0, wr_drop}, 32'd0);

`ifdef REGFILE_MP_BYPASS_EN
    applyStimulus(0, 0, 1, 5'd7, 32'hA5A5A5A5, 5'd0, 5'd7);
    @(negedge wclk);
    checkOutput("bypass_do_b", do_b, 32'hA5A5A5A5);
`endif

    applyStimulus(0, 1, 1, 5'd3, 32'hCAFE0003, 5'd3, 5'd3);
    @(negedge wclk);
    checkOutput("clr_accept_busy", {31'd0, busy}, 32'd0);
    applyStimulus(0, 0, 1, 5'd9, 32'h00001111, 5'd3, 5'd9);
    @(negedge wclk);
    checkOutput("clr_busy_high", {31'd0, busy}, 32'd1);
    applyStimulus(0, 0, 0, 5'd0, 32'd0, 5'd3, 5'd9);
    @(negedge wclk);
    checkOutput("wr_drop_pulse", {31'd0, wr_drop}, 32'd1);
    #1;
    countBusyEdges(1, n);
    checkOutput("clr_clear_edges", n, 32'd32);
    raddr_a = 5'd3;
    raddr_b = 5'd9;
    @(negedge wclk);
    checkOutput("addr3_cleared", do_a, 32'd0);
    checkOutput("addr9_dropped", do_b, 32'd0);

    applyStimulus(0, 1, 0, 5'd0, 32'd0, 5'd1, 5'd2);
    applyStimulus(0, 0, 0, 5'd0, 32'd0, 5'd1, 5'd2);
    repeat (10) @(posedge wclk);
    #1;
    rst = 1'b1;
    @(posedge wclk);
    #1;
    rst = 1'b0;
    countBusyEdges(0, n);
    checkOutput("rst_mid_clear_edges", n, 32'd32);

    for (int i = 0; i < 3000; i++) begin
      logic [4:0] wa;
      wa = 5'($urandom);
      applyStimulus($urandom_range(0, 499) == 0, $urandom_range(0, 99) == 0,
                    1'($urandom), wa, $urandom,
                    ($urandom_range(0, 3) == 0) ? wa : 5'($urandom),
                    ($urandom_range(0, 3) == 0) ? wa : 5'($urandom));
    end
    applyStimulus(0, 0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
    @(negedge wclk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
